// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and accepted-key report bundle
interface keypad_scanner_if;
    logic [3:0] rows_L;
    logic [3:0] cols_L;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows_L,
        output cols_L, key_code, key_valid, key_held
    );

    modport slave (
        output rows_L,
        input  cols_L, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with scan-level debounce and ghost rejection
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic               CLK,
    input logic               RST,
    keypad_scanner_if.master  kp
);
    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DS         = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    logic [3:0]    rows_s1, rows_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;

    state_t     state, state_next;
    logic [3:0] cand, cand_next, cnt, cnt_next, rel, rel_next;
    logic [3:0] key_code_r;
    logic       key_valid_r, accept, key_held_c;

    logic [3:0] pressed;
    logic [2:0] col_hits, hit_sum;
    logic [1:0] col_row, keys_now;
    logic [3:0] code_now;
    logic       terminal, scan_end;

    assign pressed  = ~rows_s2;
    assign terminal = (dwell == DWELL_LAST);
    assign scan_end = terminal && (col == 2'd3);

    // Lowest pressed row wins the code; it only matters when exactly one is down.
    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (pressed[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
    end

    assign hit_sum  = {1'b0, acc_cnt} + col_hits;
    assign keys_now = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign code_now = (acc_cnt == 2'd0 && col_hits == 3'd1) ? {col, col_row} : acc_code;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rows_s1  <= 4'b1111;
            rows_s2  <= 4'b1111;
            dwell    <= '0;
            col      <= 2'd0;
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            rows_s1 <= kp.rows_L;
            rows_s2 <= rows_s1;
            dwell   <= terminal ? '0 : dwell + DW'(1);
            if (terminal) begin
                col <= col + 2'd1;
                if (scan_end) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_cnt  <= keys_now;
                    acc_code <= code_now;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cand        <= 4'd0;
            cnt         <= 4'd0;
            rel         <= 4'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
        end else begin
            state       <= state_next;
            cand        <= cand_next;
            cnt         <= cnt_next;
            rel         <= rel_next;
            key_valid_r <= accept;
            if (accept) key_code_r <= cand;
        end
    end

    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        rel_next   = rel;
        accept     = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (keys_now == 2'd1) begin
                        cand_next  = code_now;
                        cnt_next   = 4'd1;
                        state_next = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (keys_now != 2'd1) begin
                        cnt_next   = 4'd0;
                        state_next = IDLE;
                    end else if (code_now != cand) begin
                        cand_next = code_now;
                        cnt_next  = 4'd1;
                    end else if (cnt + 4'd1 == DS) begin
                        accept     = 1'b1;
                        cnt_next   = 4'd0;
                        rel_next   = 4'd0;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (keys_now != 2'd0) begin
                        rel_next = 4'd0;
                    end else if (rel + 4'd1 == DS) begin
                        rel_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        rel_next = rel + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        key_held_c = (state == HELD);
    end

    assign kp.cols_L    = ~(4'b0001 << col);
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_c;
endmodule
